// File: rtl/avalon_st_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS Avalon-ST sources
// onto a single Avalon-ST sink. A grant is held from sop through eop.

package general_pack;

  // Bits needed to encode 0..value-1, never less than 1.
  function automatic int unsigned log2up_func(input int unsigned value);
    int unsigned result;
    result = 1;
    while ((64'd1 << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

module avalon_st_packet_arbiter #(
  parameter int unsigned NUM_INPUTS          = 4,
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  localparam int unsigned DW = 8 * DATA_WIDTH_IN_BYTES,
  localparam int unsigned EW = general_pack::log2up_func(DATA_WIDTH_IN_BYTES),
  localparam int unsigned CW = general_pack::log2up_func(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0][DW-1:0]    in_data,
  input  logic [NUM_INPUTS-1:0]            in_sop,
  input  logic [NUM_INPUTS-1:0]            in_eop,
  input  logic [NUM_INPUTS-1:0][EW-1:0]    in_empty,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DW-1:0]                    out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [EW-1:0]                    out_empty,
  output logic [CW-1:0]                    out_channel,
  input  logic                             out_ready
);

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSFER = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] grant;
  logic [CW-1:0] grant_nxt;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] last_grant_nxt;

  logic [NUM_INPUTS-1:0] req;
  logic                  found;
  logic [CW-1:0]         sel;

  logic          gnt_valid;
  logic [DW-1:0] gnt_data;
  logic          gnt_sop;
  logic          gnt_eop;
  logic [EW-1:0] gnt_empty;

  // Only a valid start-of-packet beat can request the stream.
  assign req = in_valid & in_sop;

  // Round-robin search: first requester above last_grant, else lowest at or below it.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
      if (!found && req[j] && (CW'(j) > last_grant)) begin
        found = 1'b1;
        sel   = CW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
      if (!found && req[j] && (CW'(j) <= last_grant)) begin
        found = 1'b1;
        sel   = CW'(j);
      end
    end
  end

  // Select the granted input; only legal index codes are ever matched.
  always_comb begin
    gnt_valid = in_valid[0];
    gnt_data  = in_data[0];
    gnt_sop   = in_sop[0];
    gnt_eop   = in_eop[0];
    gnt_empty = in_empty[0];
    for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
      if (grant == CW'(j)) begin
        gnt_valid = in_valid[j];
        gnt_data  = in_data[j];
        gnt_sop   = in_sop[j];
        gnt_eop   = in_eop[j];
        gnt_empty = in_empty[j];
      end
    end
  end

  // Next-state logic and combinational stream outputs.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    out_valid      = 1'b0;
    in_ready       = '0;
    out_data       = gnt_data;
    out_sop        = gnt_sop;
    out_eop        = gnt_eop;
    out_empty      = gnt_empty;
    out_channel    = grant;

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = sel;
          state_nxt = TRANSFER;
        end
      end
      TRANSFER: begin
        out_valid = gnt_valid;
        for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
          if (grant == CW'(j)) in_ready[j] = out_ready;
        end
        if (gnt_valid && out_ready && gnt_eop) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset leaves input 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CW'(NUM_INPUTS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Self-checking bench for avalon_st_packet_arbiter: a 4-input/16-byte
// instance driven from a vector table with a beat scoreboard, plus a
// 3-input instance exercising the non-power-of-two wrap.

module tb_avalon_st_packet_arbiter;

  logic clk;
  logic rst;

  // 4-input, 16-byte instance
  logic [3:0]        in_valid;
  logic [3:0][127:0] in_data;
  logic [3:0]        in_sop;
  logic [3:0]        in_eop;
  logic [3:0][3:0]   in_empty;
  logic [3:0]        in_ready;
  logic              out_valid;
  logic [127:0]      out_data;
  logic              out_sop;
  logic              out_eop;
  logic [3:0]        out_empty;
  logic [1:0]        out_channel;
  logic              out_ready;

  // 3-input, 4-byte instance
  logic [2:0]        v3_valid;
  logic [2:0][31:0]  v3_data;
  logic [2:0]        v3_sop;
  logic [2:0]        v3_eop;
  logic [2:0][1:0]   v3_empty;
  logic [2:0]        v3_ready;
  logic              v3_out_valid;
  logic [31:0]       v3_out_data;
  logic              v3_out_sop;
  logic              v3_out_eop;
  logic [1:0]        v3_out_empty;
  logic [1:0]        v3_out_channel;
  logic              v3_out_ready;

  int tests  = 0;
  int failed = 0;
  int step   = 0;

  avalon_st_packet_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH_IN_BYTES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty), .out_channel(out_channel),
    .out_ready(out_ready)
  );

  avalon_st_packet_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH_IN_BYTES(4)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(v3_valid), .in_data(v3_data), .in_sop(v3_sop), .in_eop(v3_eop),
    .in_empty(v3_empty), .in_ready(v3_ready),
    .out_valid(v3_out_valid), .out_data(v3_out_data), .out_sop(v3_out_sop),
    .out_eop(v3_out_eop), .out_empty(v3_out_empty), .out_channel(v3_out_channel),
    .out_ready(v3_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] sop;
    logic [3:0] eop;
    logic       ordy;
    logic       ov;
    logic [1:0] ch;
    logic [3:0] ir;
    logic       osop;
    logic       oeop;
  } vec_t;

  typedef struct {
    logic [1:0]   ch;
    logic [127:0] data;
    logic         eop;
    logic [3:0]   empty;
  } beat_t;

  typedef struct {
    logic [2:0] vld;
    logic       ov;
    logic [1:0] ch;
  } v3_t;

  vec_t  vecs[$];
  beat_t sb[$];
  v3_t   t3[$];

  function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [3:0] sop,
                              input logic [3:0] eop, input logic ordy, input logic ov,
                              input logic [1:0] ch, input logic [3:0] ir,
                              input logic osop, input logic oeop);
    vec_t v;
    v.rst = r; v.vld = vld; v.sop = sop; v.eop = eop; v.ordy = ordy;
    v.ov = ov; v.ch = ch; v.ir = ir; v.osop = osop; v.oeop = oeop;
    return v;
  endfunction

  function automatic v3_t mk3(input logic [2:0] vld, input logic ov, input logic [1:0] ch);
    v3_t v;
    v.vld = vld; v.ov = ov; v.ch = ch;
    return v;
  endfunction

  function automatic logic [127:0] pat(input int i, input int s);
    return {96'd0, 8'(s), 8'(i), 16'hBEEF};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (step %0d): got %h expected %h", name, step, act, exp);
    end
  endtask

  // One table row: drive at negedge, sample 1ns later, then the posedge follows.
  task automatic run_vec(input vec_t v);
    beat_t b;
    @(negedge clk);
    rst       = v.rst;
    in_valid  = v.vld;
    in_sop    = v.sop;
    in_eop    = v.eop;
    out_ready = v.ordy;
    for (int i = 0; i < 4; i++) begin
      in_data[i]  = pat(i, step);
      in_empty[i] = 4'(i + step);
    end
    if (v.ov && v.ordy) begin
      b.ch    = v.ch;
      b.data  = pat(int'(v.ch), step);
      b.eop   = v.oeop;
      b.empty = 4'(int'(v.ch) + step);
      sb.push_back(b);
    end
    #1;
    check("out_valid", 128'(out_valid), 128'(v.ov));
    check("in_ready", 128'(in_ready), 128'(v.ir));
    if (v.ov) begin
      check("out_channel", 128'(out_channel), 128'(v.ch));
      check("out_sop", 128'(out_sop), 128'(v.osop));
      check("out_eop", 128'(out_eop), 128'(v.oeop));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected (step %0d): got beat on channel %0d expected none", step, out_channel);
      end else begin
        b = sb.pop_front();
        check("sb_data", out_data, b.data);
        check("sb_empty", 128'(out_empty), 128'(b.empty));
        check("sb_channel", 128'(out_channel), 128'(b.ch));
        check("sb_eop", 128'(out_eop), 128'(b.eop));
      end
    end
    step++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0; out_ready = 1'b0;
    v3_valid = '0; v3_sop = '0; v3_eop = '0; v3_data = '0; v3_empty = '0; v3_out_ready = 1'b1;

    // Reset state, then priority order 0,1,2,3,0 with a bubble between packets
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 0, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 1, 2'(k % 4), 4'(1 << (k % 4)), 1, 1));
    end
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    // Valid without sop in IDLE is not a request
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    // 3-beat packet on input 2 with a 2-cycle stall; input 0 waits
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0101, 4'b0000, 1, 1, 2, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 4'b0000, 0, 1, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 4'b0000, 0, 1, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 4'b0000, 1, 1, 2, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 4'b0100, 1, 1, 2, 4'b0100, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 4'b0001, 1, 1));
    // Granted input drops valid mid-packet; input 3 does not preempt
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1000, 4'b0010, 1, 1, 1, 4'b0010, 0, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 1, 3, 4'b1000, 1, 1));
    // Reset on beat 2 of input 1 while input 3 requests
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 4'b0000, 1, 1, 1, 4'b0010, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'b1000, 4'b0000, 1, 1, 1, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 1, 3, 4'b1000, 1, 1));
    // Reset again with inputs 0 and 3 requesting: input 0 first
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 4'b1001, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b1001, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b1001, 1, 1, 0, 4'b0001, 1, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 1, 3, 4'b1000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));

    // 3-input wrap: last from 2 -> {0,1} picks 0 -> {1,2} picks 1 -> {0,2} picks 2 then 0
    t3.push_back(mk3(3'b100, 0, 0));
    t3.push_back(mk3(3'b100, 1, 2));
    t3.push_back(mk3(3'b011, 0, 0));
    t3.push_back(mk3(3'b011, 1, 0));
    t3.push_back(mk3(3'b110, 0, 0));
    t3.push_back(mk3(3'b110, 1, 1));
    t3.push_back(mk3(3'b101, 0, 0));
    t3.push_back(mk3(3'b101, 1, 2));
    t3.push_back(mk3(3'b101, 0, 0));
    t3.push_back(mk3(3'b101, 1, 0));
    t3.push_back(mk3(3'b000, 0, 0));

    @(posedge clk);

    foreach (vecs[n]) run_vec(vecs[n]);
    check("sb_drain", 128'(sb.size()), 128'(0));

    // Full-width data and empty passthrough on input 1 (last grant is 3)
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 4'b0010; in_sop = 4'b0010; in_eop = 4'b0010;
    in_data[1] = {16{8'hA5}}; in_empty[1] = 4'd7;
    #1;
    check("pt_idle_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    #1;
    check("pt_valid", 128'(out_valid), 128'(1));
    check("pt_channel", 128'(out_channel), 128'(1));
    check("pt_data", out_data, {16{8'hA5}});
    check("pt_empty", 128'(out_empty), 128'(7));
    check("pt_eop", 128'(out_eop), 128'(1));
    check("pt_ready", 128'(in_ready), 128'(4'b0010));
    @(negedge clk);
    in_valid = '0; in_sop = '0; in_eop = '0;
    #1;
    check("pt_after_valid", 128'(out_valid), 128'(0));

    // Non-power-of-two instance
    foreach (t3[n]) begin
      @(negedge clk);
      v3_valid = t3[n].vld; v3_sop = t3[n].vld; v3_eop = t3[n].vld;
      for (int i = 0; i < 3; i++) v3_data[i] = 32'(32'hC0DE_0000 + i);
      #1;
      check("v3_out_valid", 128'(v3_out_valid), 128'(t3[n].ov));
      check("v3_in_ready", 128'(v3_ready), t3[n].ov ? 128'(3'(1) << t3[n].ch) : 128'(0));
      if (t3[n].ov) begin
        check("v3_channel", 128'(v3_out_channel), 128'(t3[n].ch));
        check("v3_data", 128'(v3_out_data), 128'(32'hC0DE_0000 + 32'(t3[n].ch)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
